// File: rtl/oai32_bist_pkg.sv
// Shared types, widths and the golden OAI32 model for the BIST sequencer.
package oai32_bist_pkg;

    localparam int unsigned VEC_W = 5;
    localparam int unsigned ERR_W = 6;

    typedef enum logic [2:0] {
        StIdle,
        StDrive,
        StSettle,
        StSample,
        StDone
    } state_e;

    // Vector layout is {B2,B1,A3,A2,A1}.
    function automatic logic oai32_exp(input logic [VEC_W-1:0] vec);
        return !((vec[0] | vec[1] | vec[2]) & (vec[3] | vec[4]));
    endfunction

endpackage

// File: rtl/oai32_bist_settle_cnt.sv
// Loadable down-counter with a zero flag; holds at zero rather than wrapping.
module oai32_bist_settle_cnt #(
    parameter int unsigned W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Load has priority over decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/oai32_bist_seq.sv
// Exhaustive BIST driver/checker for one OAI32 cell: walks all 32 vectors,
// waits SETTLE_CYCLES, samples ZN and records error count and first failure.
module oai32_bist_seq
    import oai32_bist_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2  // legal range 1..15
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             ZN,
    output logic             A1,
    output logic             A2,
    output logic             A3,
    output logic             B1,
    output logic             B2,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic [VEC_W-1:0] FAIL_VEC,
    output logic             FAIL_VALID
);

    localparam logic [3:0] SettleLoad = 4'(SETTLE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [VEC_W-1:0] vec_q, vec_d;
    logic [VEC_W-1:0] stim_q, stim_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [VEC_W-1:0] fail_vec_q, fail_vec_d;
    logic             fail_valid_q, fail_valid_d;
    logic             done_q, done_d;
    logic             settle_zero;

    oai32_bist_settle_cnt #(
        .W (4)
    ) u_settle_cnt (
        .clk_i      (CLK),
        .rst_i      (RST),
        .load_i     (state_q == StDrive),
        .load_val_i (SettleLoad),
        .dec_i      (state_q == StSettle),
        .zero_o     (settle_zero)
    );

    // Next-state and datapath updates for the vector walk.
    always_comb begin
        state_d      = state_q;
        vec_d        = vec_q;
        stim_d       = stim_q;
        err_cnt_d    = err_cnt_q;
        fail_vec_d   = fail_vec_q;
        fail_valid_d = fail_valid_q;
        done_d       = done_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (START) begin
                    vec_d        = '0;
                    err_cnt_d    = '0;
                    fail_vec_d   = '0;
                    fail_valid_d = 1'b0;
                    done_d       = 1'b0;
                    state_d      = StDrive;
                end
            end
            StDrive: begin
                stim_d  = vec_q;
                state_d = StSettle;
            end
            StSettle: begin
                if (settle_zero) begin
                    state_d = StSample;
                end
            end
            StSample: begin
                if (ZN != oai32_exp(vec_q)) begin
                    err_cnt_d = err_cnt_q + ERR_W'(1);
                    if (!fail_valid_q) begin
                        fail_vec_d   = vec_q;
                        fail_valid_d = 1'b1;
                    end
                end
                // Vector 31 is terminal; the index never wraps.
                if (vec_q == 5'd31) begin
                    done_d  = 1'b1;
                    state_d = StDone;
                end else begin
                    vec_d   = vec_q + VEC_W'(1);
                    state_d = StDrive;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; RST overrides everything including START.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= StIdle;
            vec_q        <= '0;
            stim_q       <= '0;
            err_cnt_q    <= '0;
            fail_vec_q   <= '0;
            fail_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_q        <= vec_d;
            stim_q       <= stim_d;
            err_cnt_q    <= err_cnt_d;
            fail_vec_q   <= fail_vec_d;
            fail_valid_q <= fail_valid_d;
            done_q       <= done_d;
        end
    end

    assign {B2, B1, A3, A2, A1} = stim_q;
    assign BUSY       = (state_q == StDrive) || (state_q == StSettle) || (state_q == StSample);
    assign DONE       = done_q;
    assign PASS       = done_q && (err_cnt_q == '0);
    assign ERR_CNT    = err_cnt_q;
    assign FAIL_VEC   = fail_vec_q;
    assign FAIL_VALID = fail_valid_q;

endmodule
